// File: rtl/pixel_fb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_fb_pkg : framebuffer geometry, queued-write type, coord-to-address  |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
package pixel_fb_pkg;

  localparam int H_RES  = 128;
  localparam int V_RES  = 64;
  localparam int X_W    = $clog2(H_RES);
  localparam int Y_W    = $clog2(V_RES);
  localparam int ADDR_W = X_W + Y_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              value;
  } pix_wr_t;

  function automatic logic coord_in_range(input logic [31:0] coord);
    return (coord[15:0] < 16'(H_RES)) && (coord[31:16] < 16'(V_RES));
  endfunction

  // Row-major packing: low bits of y above low bits of x.
  function automatic logic [ADDR_W-1:0] coord_to_addr(input logic [31:0] coord);
    return {coord[16 +: Y_W], coord[0 +: X_W]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_fb_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_fb_if : single-port 1-bit framebuffer RAM bus (arbiter <-> RAM)     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface pixel_fb_if;
  import pixel_fb_pkg::*;

  logic              fb_en;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic              fb_wdata;
  logic              fb_rdata;

  modport master (output fb_en, output fb_we, output fb_addr, output fb_wdata, input fb_rdata);
  modport slave  (input fb_en, input fb_we, input fb_addr, input fb_wdata, output fb_rdata);

endinterface
`default_nettype wire

// File: rtl/pix_wr_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pix_wr_fifo : pending pixel-write queue; tail-overwrite port present only  |
// |               when PIXEL_COALESCE_EN is defined.      Revision : 1.0       |
// +----------------------------------------------------------------------------+
module pix_wr_fifo
  import pixel_fb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              push,
  input  wire pix_wr_t           push_data,
  input  wire logic              pop,
`ifdef PIXEL_COALESCE_EN
  input  wire logic              tail_wr,
  input  wire logic              tail_value,
  output      logic [ADDR_W-1:0] tail_addr,
`endif
  output      pix_wr_t           head,
  output      logic              full,
  output      logic              empty,
  output      logic [LVL_W-1:0]  level
);

  pix_wr_t          mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

`ifdef PIXEL_COALESCE_EN
  logic [PTR_W-1:0] w_tail_idx;
  assign w_tail_idx = r_wr_ptr - PTR_W'(1);
  assign tail_addr  = mem[w_tail_idx].addr;
`endif

  // Storage carries no reset; occupancy is defined solely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[r_wr_ptr] <= push_data;
`ifdef PIXEL_COALESCE_EN
    if (tail_wr) mem[w_tail_idx].value <= tail_value;
`endif
  end

  assign head  = mem[r_rd_ptr];
  assign level = r_level;
  assign full  = (r_level == LVL_W'(DEPTH));
  assign empty = (r_level == '0);

endmodule
`default_nettype wire

// File: rtl/pixel_fb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_fb_arbiter : shares the framebuffer RAM between queued CPU pixel     |
// |   writes and display reads; option macro PIXEL_COALESCE_EN. Revision 1.0   |
// +----------------------------------------------------------------------------+
module pixel_fb_arbiter
  import pixel_fb_pkg::*;
#(
  parameter  int FIFO_DEPTH   = 4,
  parameter  int STARVE_LIMIT = 8,
  localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1,
  localparam int SC_W         = $clog2(STARVE_LIMIT + 1)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              pix_wr_en,
  input  wire logic [31:0]       pix_coord,
  input  wire logic              pix_value,
  output      logic              cpu_stall,
  input  wire logic              disp_rd_req,
  input  wire logic [ADDR_W-1:0] disp_rd_addr,
  output      logic              disp_rd_gnt,
  output      logic              disp_rd_valid,
  output      logic              disp_rd_data,
  pixel_fb_if.master             fb,
  output      logic [LVL_W-1:0]  fifo_level,
  output      logic [7:0]        drop_cnt
);

  pix_wr_t          w_new;
  pix_wr_t          w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_ok;
  logic             w_drop;
  logic             w_force;
  logic             w_pop;
  logic             w_push;
  logic             w_coalesce;
  logic [SC_W-1:0]  r_starve;
  logic [7:0]       r_drop;
  logic             r_rd_valid;

  assign w_new = '{addr: coord_to_addr(pix_coord), value: pix_value};

`ifdef PIXEL_COALESCE_EN
  logic [ADDR_W-1:0] w_tail_addr;
`endif

  pix_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (w_push),
    .push_data  (w_new),
    .pop        (w_pop),
`ifdef PIXEL_COALESCE_EN
    .tail_wr    (w_coalesce),
    .tail_value (pix_value),
    .tail_addr  (w_tail_addr),
`endif
    .head       (w_head),
    .full       (w_full),
    .empty      (w_empty),
    .level      (fifo_level)
  );

  // Every combinational output is forced low while rst is asserted.
  always_comb begin
    w_wr_ok     = !rst && pix_wr_en && coord_in_range(pix_coord);
    w_drop      = !rst && pix_wr_en && !coord_in_range(pix_coord);
    w_force     = (r_starve == SC_W'(STARVE_LIMIT)) && !w_empty;
    disp_rd_gnt = !rst && disp_rd_req && !w_force;
    w_pop       = !rst && !disp_rd_gnt && !w_empty;
`ifdef PIXEL_COALESCE_EN
    // Merge into the tail unless that entry is leaving the queue right now.
    w_coalesce  = w_wr_ok && !w_empty && (w_tail_addr == w_new.addr) &&
                  !(w_pop && (fifo_level == LVL_W'(1)));
`else
    w_coalesce  = 1'b0;
`endif
    w_push      = w_wr_ok && !w_coalesce && (!w_full || w_pop);
    cpu_stall   = w_wr_ok && !w_coalesce && w_full && !w_pop;

    fb.fb_en    = 1'b0;
    fb.fb_we    = 1'b0;
    fb.fb_addr  = '0;
    fb.fb_wdata = 1'b0;
    if (disp_rd_gnt) begin
      fb.fb_en   = 1'b1;
      fb.fb_addr = disp_rd_addr;
    end else if (w_pop) begin
      fb.fb_en    = 1'b1;
      fb.fb_we    = 1'b1;
      fb.fb_addr  = w_head.addr;
      fb.fb_wdata = w_head.value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve   <= '0;
      r_drop     <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= disp_rd_gnt;
      if (w_pop)
        r_starve <= '0;
      else if (disp_rd_gnt && !w_empty && (r_starve != SC_W'(STARVE_LIMIT)))
        r_starve <= r_starve + SC_W'(1);
      if (w_drop && (r_drop != 8'hFF))
        r_drop <= r_drop + 8'd1;
    end
  end

  // RAM output is already registered; it is qualified by the delayed grant.
  assign disp_rd_valid = r_rd_valid;
  assign disp_rd_data  = r_rd_valid & fb.fb_rdata;
  assign drop_cnt      = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_pixel_fb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pixel_fb_arbiter : directed self-checking bench with a 1-cycle RAM      |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
module tb_pixel_fb_arbiter;
  import pixel_fb_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              pix_wr_en;
  logic [31:0]       pix_coord;
  logic              pix_value;
  logic              cpu_stall;
  logic              disp_rd_req;
  logic [ADDR_W-1:0] disp_rd_addr;
  logic              disp_rd_gnt;
  logic              disp_rd_valid;
  logic              disp_rd_data;
  logic [2:0]        fifo_level;
  logic [7:0]        drop_cnt;

  int checks   = 0;
  int failures = 0;

  pixel_fb_if fb_bus ();

  pixel_fb_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .pix_wr_en     (pix_wr_en),
    .pix_coord     (pix_coord),
    .pix_value     (pix_value),
    .cpu_stall     (cpu_stall),
    .disp_rd_req   (disp_rd_req),
    .disp_rd_addr  (disp_rd_addr),
    .disp_rd_gnt   (disp_rd_gnt),
    .disp_rd_valid (disp_rd_valid),
    .disp_rd_data  (disp_rd_data),
    .fb            (fb_bus.master),
    .fifo_level    (fifo_level),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  // Framebuffer RAM model, one-cycle read latency.
  logic ram [0:(1<<ADDR_W)-1];
  logic ram_q = 1'b0;
  initial for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 1'b0;
  always @(posedge clk) begin
    if (fb_bus.fb_en) begin
      if (fb_bus.fb_we) ram[fb_bus.fb_addr] <= fb_bus.fb_wdata;
      else              ram_q <= ram[fb_bus.fb_addr];
    end
  end
  assign fb_bus.fb_rdata = ram_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [4:0] vals;

  initial begin
    rst = 1'b1; pix_wr_en = 1'b0; pix_coord = '0; pix_value = 1'b0;
    disp_rd_req = 1'b0; disp_rd_addr = '0;
    tick(); tick();

    // Requests during reset must not reach the combinational outputs.
    pix_wr_en = 1'b1; pix_coord = {16'd2, 16'd3}; disp_rd_req = 1'b1; #1;
    chk("rst_stall", 32'(cpu_stall), 0);
    chk("rst_gnt",   32'(disp_rd_gnt), 0);
    chk("rst_fb_en", 32'(fb_bus.fb_en), 0);
    pix_wr_en = 1'b0; disp_rd_req = 1'b0;
    tick();
    rst = 1'b0; #1;
    chk("reset_level", 32'(fifo_level), 0);
    chk("reset_drop",  32'(drop_cnt), 0);
    chk("reset_valid", 32'(disp_rd_valid), 0);
    chk("reset_data",  32'(disp_rd_data), 0);

    // Test 1: write (3,2)=1, idle display.
    pix_wr_en = 1'b1; pix_coord = {16'd2, 16'd3}; pix_value = 1'b1; #1;
    chk("t1_no_stall", 32'(cpu_stall), 0);
    chk("t1_no_bypass", 32'(fb_bus.fb_en), 0);
    tick();
    pix_wr_en = 1'b0; #1;
    chk("t1_level1", 32'(fifo_level), 1);
    chk("t1_we",     32'(fb_bus.fb_we), 1);
    chk("t1_addr",   32'(fb_bus.fb_addr), 32'h103);
    chk("t1_wdata",  32'(fb_bus.fb_wdata), 1);
    tick();
    chk("t1_level0", 32'(fifo_level), 0);
    chk("t1_idle",   32'(fb_bus.fb_en), 0);

    // Test 4: read back 0x103.
    disp_rd_req = 1'b1; disp_rd_addr = 13'h103; #1;
    chk("t4_gnt",  32'(disp_rd_gnt), 1);
    chk("t4_en",   32'(fb_bus.fb_en), 1);
    chk("t4_we",   32'(fb_bus.fb_we), 0);
    chk("t4_addr", 32'(fb_bus.fb_addr), 32'h103);
    tick();
    disp_rd_req = 1'b0; #1;
    chk("t4_valid", 32'(disp_rd_valid), 1);
    chk("t4_data",  32'(disp_rd_data), 1);
    tick();
    chk("t4_valid_drop", 32'(disp_rd_valid), 0);

    // Test 2: five writes with display always requesting.
    vals = 5'b01101;
    disp_rd_req = 1'b1; disp_rd_addr = '0;
    for (int k = 0; k < 4; k++) begin
      pix_wr_en = 1'b1; pix_coord = {16'd0, 16'(10 + k)}; pix_value = vals[k]; #1;
      chk("t2_fill_stall", 32'(cpu_stall), 0);
      chk("t2_fill_gnt",   32'(disp_rd_gnt), 1);
      tick();
    end
    pix_coord = {16'd0, 16'd14}; pix_value = vals[4];
    for (int c = 4; c <= 8; c++) begin
      #1;
      chk("t2_stall", 32'(cpu_stall), 1);
      chk("t2_gnt",   32'(disp_rd_gnt), 1);
      chk("t2_full",  32'(fifo_level), 4);
      tick();
    end
    #1;
    chk("t2_force_gnt",   32'(disp_rd_gnt), 0);
    chk("t2_force_stall", 32'(cpu_stall), 0);
    chk("t2_force_we",    32'(fb_bus.fb_we), 1);
    chk("t2_force_addr",  32'(fb_bus.fb_addr), 10);
    chk("t2_force_wdata", 32'(fb_bus.fb_wdata), 1);
    tick();
    pix_wr_en = 1'b0; #1;
    chk("t2_gnt_resume", 32'(disp_rd_gnt), 1);
    chk("t2_level",      32'(fifo_level), 4);
    disp_rd_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t2_drained", 32'(fifo_level), 0);
    chk("t2_ram_order", 32'({ram[14], ram[13], ram[12], ram[11], ram[10]}), 32'(vals));

    // Test 3: out-of-range writes.
    pix_wr_en = 1'b1; pix_coord = {16'd5, 16'd200}; pix_value = 1'b1; #1;
    chk("t3_no_stall", 32'(cpu_stall), 0);
    tick();
    chk("t3_no_push", 32'(fifo_level), 0);
    chk("t3_drop1",   32'(drop_cnt), 1);
    pix_coord = {16'd64, 16'd0};
    for (int i = 0; i < 300; i++) tick();
    pix_wr_en = 1'b0; #1;
    chk("t3_sat",    32'(drop_cnt), 255);
    chk("t3_no_ram", 32'(fb_bus.fb_en), 0);
    tick();

    // Test 5: full FIFO, simultaneous pop and push, then reset mid-queue.
    disp_rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pix_wr_en = 1'b1; pix_coord = {16'd1, 16'(20 + k)}; pix_value = 1'b1;
      tick();
    end
    chk("t5_full", 32'(fifo_level), 4);
    disp_rd_req = 1'b0; pix_coord = {16'd1, 16'd24}; #1;
    chk("t5_pp_stall", 32'(cpu_stall), 0);
    chk("t5_pp_addr",  32'(fb_bus.fb_addr), 148);
    tick();
    pix_wr_en = 1'b0; disp_rd_req = 1'b1; #1;
    chk("t5_level4", 32'(fifo_level), 4);
    rst = 1'b1; #1;
    chk("t5_rst_gnt", 32'(disp_rd_gnt), 0);
    chk("t5_rst_en",  32'(fb_bus.fb_en), 0);
    tick();
    rst = 1'b0; disp_rd_req = 1'b0; #1;
    chk("t5_rst_level", 32'(fifo_level), 0);
    chk("t5_rst_drop",  32'(drop_cnt), 0);
    chk("t5_rst_no_we", 32'(fb_bus.fb_en), 0);
    tick();
    chk("t5_rst_no_we2", 32'(fb_bus.fb_en), 0);

    // Test 6: two writes to (1,1) while the display holds the RAM.
    disp_rd_req = 1'b1;
    pix_wr_en = 1'b1; pix_coord = {16'd1, 16'd1}; pix_value = 1'b1;
    tick();
    pix_value = 1'b0; #1;
    chk("t6_stall", 32'(cpu_stall), 0);
    tick();
    pix_wr_en = 1'b0; #1;
`ifdef PIXEL_COALESCE_EN
    chk("t6_level", 32'(fifo_level), 1);
`else
    chk("t6_level", 32'(fifo_level), 2);
`endif
    disp_rd_req = 1'b0; #1;
    chk("t6_we1",   32'(fb_bus.fb_we), 1);
    chk("t6_addr1", 32'(fb_bus.fb_addr), 129);
`ifdef PIXEL_COALESCE_EN
    chk("t6_wdata1", 32'(fb_bus.fb_wdata), 0);
    tick();
    chk("t6_done", 32'(fb_bus.fb_en), 0);
`else
    chk("t6_wdata1", 32'(fb_bus.fb_wdata), 1);
    tick();
    chk("t6_we2",    32'(fb_bus.fb_we), 1);
    chk("t6_wdata2", 32'(fb_bus.fb_wdata), 0);
`endif
    tick();
    chk("t6_ram", 32'(ram[129]), 0);
    chk("t6_empty", 32'(fifo_level), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
